// File: rtl/ltc1197_spi_master_pkg.sv
// Shared constants and types for the LTC1197 SPI read master.
// Holds the ADC frame geometry, default timing and the controller state encoding.
package ltc1197_spi_master_pkg;

  // LTC1197 frame geometry: spi_clk periods per frame, leading dead periods, data bits.
  localparam int unsigned LTC_N_FRAME = 14;
  localparam int unsigned LTC_N_SKIP  = 3;
  localparam int unsigned LTC_N_DATA  = 10;

  // Default timing in system clocks (100 MHz system clock).
  localparam int unsigned DEF_CLK_HALF = 7;
  localparam int unsigned DEF_T_CSS    = 4;
  localparam int unsigned DEF_T_CSH    = 14;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSclkHi,
    StSclkLo,
    StRecover
  } state_e;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ltc1197_spi_master_spi_half_timer.sv
// Loadable down-counter with a terminal-count flag.
// Loading D-1 on entry to a phase makes o_tc high on the last of D cycles.
// Ports:
//   clk, reset_b  system clock, asynchronous active-low reset
//   i_load        load i_load_val on the next edge (takes priority over counting)
//   i_load_val    value to load
//   o_tc          high while the count is zero
module ltc1197_spi_master_spi_half_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_load) begin
      w_cnt_d = i_load_val;
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/ltc1197_spi_master.sv
// SPI read master for the LTC1197 10-bit ADC.
// Each accepted start runs one frame: cs low, N_FRAME spi_clk periods, MSB-first capture of
// N_DATA bits after N_SKIP dead periods, then a cs-high recovery interval.
// Ports:
//   clk, reset_b      system clock, asynchronous active-low reset
//   i_start           conversion request, honoured only when idle
//   i_miso            ADC serial data
//   o_cs              ADC chip select, active low
//   o_spi_clk         serial clock, idles low
//   o_sample          last completed conversion
//   o_sample_valid    one-cycle strobe marking a new o_sample
//   o_busy            high from accepted start to the end of recovery
module ltc1197_spi_master
  import ltc1197_spi_master_pkg::*;
#(
  parameter int unsigned CLK_HALF = DEF_CLK_HALF,
  parameter int unsigned N_FRAME  = LTC_N_FRAME,
  parameter int unsigned N_SKIP   = LTC_N_SKIP,
  parameter int unsigned N_DATA   = LTC_N_DATA,
  parameter int unsigned T_CSS    = DEF_T_CSS,
  parameter int unsigned T_CSH    = DEF_T_CSH
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              i_start,
  input  logic              i_miso,
  output logic              o_cs,
  output logic              o_spi_clk,
  output logic [N_DATA-1:0] o_sample,
  output logic              o_sample_valid,
  output logic              o_busy
);

  localparam int unsigned TW = cnt_width(max3(CLK_HALF, T_CSS, T_CSH));
  localparam int unsigned PW = cnt_width(N_FRAME + 1);

  localparam logic [PW-1:0] PSkipEnd = PW'(N_SKIP);
  localparam logic [PW-1:0] PDataEnd = PW'(N_SKIP + N_DATA);
  localparam logic [PW-1:0] PLast    = PW'(N_FRAME - 1);

  state_e            r_state, w_state_d;
  logic [PW-1:0]     r_period, w_period_d;
  logic [N_DATA-1:0] r_shift, w_shift_d;
  logic [N_DATA-1:0] r_sample;
  logic              r_sample_valid, w_sample_valid_d;
  logic              w_load;
  logic [TW-1:0]     w_load_val;
  logic              w_tc;

  ltc1197_spi_master_spi_half_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset_b    (reset_b),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // The timer is reloaded on the edge that enters each timed phase, with the phase length - 1.
  always_comb begin
    w_state_d        = r_state;
    w_period_d       = r_period;
    w_shift_d        = r_shift;
    w_sample_valid_d = 1'b0;
    w_load           = 1'b0;
    w_load_val       = '0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d  = StSetup;
          w_period_d = '0;
          w_shift_d  = '0;
          w_load     = 1'b1;
          w_load_val = TW'(T_CSS - 1);
        end
      end
      StSetup: begin
        if (w_tc) begin
          w_state_d  = StSclkHi;
          w_load     = 1'b1;
          w_load_val = TW'(CLK_HALF - 1);
        end
      end
      StSclkHi: begin
        if (w_tc) begin
          w_state_d  = StSclkLo;
          w_load     = 1'b1;
          w_load_val = TW'(CLK_HALF - 1);
        end
      end
      StSclkLo: begin
        if (w_tc) begin
          // Only data periods shift; miso is undefined in the dead and trailing periods.
          if ((r_period >= PSkipEnd) && (r_period < PDataEnd)) begin
            w_shift_d = {r_shift[N_DATA-2:0], i_miso};
          end
          w_period_d = r_period + PW'(1);
          w_load     = 1'b1;
          if (r_period == PLast) begin
            w_state_d        = StRecover;
            w_sample_valid_d = 1'b1;
            w_load_val       = TW'(T_CSH - 1);
          end else begin
            w_state_d  = StSclkHi;
            w_load_val = TW'(CLK_HALF - 1);
          end
        end
      end
      StRecover: begin
        if (w_tc) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state        <= StIdle;
      r_period       <= '0;
      r_shift        <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_period       <= w_period_d;
      r_shift        <= w_shift_d;
      r_sample_valid <= w_sample_valid_d;
      if (w_sample_valid_d) begin
        r_sample <= w_shift_d;
      end
    end
  end

  // Decoded straight from the state so an asynchronous reset drops spi_clk and raises cs at once.
  assign o_cs           = !((r_state == StSetup) || (r_state == StSclkHi) ||
                            (r_state == StSclkLo));
  assign o_spi_clk      = (r_state == StSclkHi);
  assign o_busy         = (r_state != StIdle);
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;

endmodule

// File: tb/tb_ltc1197_spi_master.sv
// Self-checking bench for ltc1197_spi_master with a behavioural LTC1197 emulator.
module tb_ltc1197_spi_master;

  localparam int NData  = 10;
  localparam int NSkip  = 3;
  localparam int NFrame = 14;

  logic             clk = 1'b0;
  logic             reset_b = 1'b0;
  logic             i_start = 1'b0;
  logic             i_miso = 1'bz;
  logic             o_cs;
  logic             o_spi_clk;
  logic [NData-1:0] o_sample;
  logic             o_sample_valid;
  logic             o_busy;

  always #5 clk = ~clk;

  ltc1197_spi_master dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .i_start        (i_start),
    .i_miso         (i_miso),
    .o_cs           (o_cs),
    .o_spi_clk      (o_spi_clk),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .o_busy         (o_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ADC emulator: bit for rising edge p is launched on that edge; Z in dead periods, X after data.
  logic [NData-1:0] emu_data = '0;
  int emu_p = 0;
  always @(posedge o_spi_clk or posedge o_cs) begin
    if (o_cs) begin
      emu_p = 0;
      i_miso <= 1'bz;
    end else begin
      if (emu_p >= NSkip && emu_p < NSkip + NData) i_miso <= emu_data[NData-1-(emu_p-NSkip)];
      else if (emu_p < NSkip) i_miso <= 1'bz;
      else i_miso <= 1'bx;
      emu_p++;
    end
  end

  // Frame monitor and scoreboard, sampled on the falling edge.
  logic [NData-1:0] sb_q[$];
  int valid_cnt = 0, rises = 0, cslow = 0, chigh = 0;
  int last_rises = 0, last_cslow = 0, min_gap = 1000;
  bit prev_cs = 1'b1, prev_sclk = 1'b0, have_frame = 1'b0, x_seen = 1'b0, bad_clk = 1'b0;

  always @(negedge clk) begin
    if (!reset_b) begin
      prev_cs    = 1'b1;
      prev_sclk  = 1'b0;
      have_frame = 1'b0;
      chigh      = 0;
    end else begin
      if ($isunknown(o_sample)) x_seen = 1'b1;
      if (o_cs && o_spi_clk) bad_clk = 1'b1;
      if (prev_cs && !o_cs) begin
        if (have_frame && chigh < min_gap) min_gap = chigh;
        rises = 0;
        cslow = 0;
        sb_q.push_back(emu_data);
      end
      if (!o_cs) begin
        cslow++;
        if (o_spi_clk && !prev_sclk) rises++;
      end else begin
        chigh++;
      end
      if (!prev_cs && o_cs) begin
        last_rises = rises;
        last_cslow = cslow;
        have_frame = 1'b1;
        chigh      = 1;
      end
      if (o_sample_valid) begin
        valid_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_valid: got sample 0x%0h expected no strobe", o_sample);
        end else begin
          check("sb_sample", 32'(o_sample), 32'(sb_q.pop_front()));
        end
      end
      prev_cs   = o_cs;
      prev_sclk = o_spi_clk;
    end
  end

  typedef struct {
    logic [NData-1:0] data;
    logic [NData-1:0] exp_sample;
    int               exp_lat;
    int               exp_rises;
    int               exp_cslow;
  } vec_t;

  vec_t vecs[5];

  // One start pulse, then latency, edge count and cs-low width against the expectations.
  task automatic run_frame(input vec_t v);
    int lat;
    emu_data = v.data;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    lat = 1;
    while (!o_sample_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("sample_value", 32'(o_sample), 32'(v.exp_sample));
    @(negedge clk);
    check("spi_clk_rises", 32'(last_rises), 32'(v.exp_rises));
    check("cs_low_cycles", 32'(last_cslow), 32'(v.exp_cslow));
    repeat (20) @(negedge clk);
    check("busy_after_recover", 32'(o_busy), 32'(0));
  endtask

  initial begin
    int vc0;
    int guard;
    bit idle_bad;

    vecs[0] = '{10'h2A5, 10'h2A5, 201, NFrame, 200};
    vecs[1] = '{10'h3FF, 10'h3FF, 201, NFrame, 200};
    vecs[2] = '{10'h000, 10'h000, 201, NFrame, 200};
    vecs[3] = '{10'h001, 10'h001, 201, NFrame, 200};
    vecs[4] = '{10'h200, 10'h200, 201, NFrame, 200};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(o_cs), 32'(1));
    check("rst_spi_clk", 32'(o_spi_clk), 32'(0));
    check("rst_sample", 32'(o_sample), 32'(0));
    check("rst_valid", 32'(o_sample_valid), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));

    reset_b = 1'b1;
    idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_cs !== 1'b1 || o_spi_clk !== 1'b0 || o_sample !== '0 ||
          o_sample_valid !== 1'b0 || o_busy !== 1'b0) idle_bad = 1'b1;
    end
    check("idle_stable", 32'(idle_bad), 32'(0));

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Start pulse mid-frame is ignored.
    vc0 = valid_cnt;
    emu_data = 10'h3C3;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (50) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (450) @(negedge clk);
    check("busy_start_ignored", 32'(valid_cnt - vc0), 32'(1));

    // Start held high: back-to-back frames separated by the recovery gap.
    vc0 = valid_cnt;
    min_gap = 1000;
    emu_data = 10'h0F0;
    @(negedge clk);
    i_start = 1'b1;
    guard = 0;
    while ((valid_cnt - vc0) < 2 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    i_start = 1'b0;
    repeat (250) @(negedge clk);
    check("held_frames", 32'(valid_cnt - vc0), 32'(2));
    check("held_gap_ge_14", 32'(min_gap >= 14), 32'(1));

    // Asynchronous reset during period 6.
    emu_data = 10'h2A5;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    guard = 0;
    while (rises < 7 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_p6", 32'(rises), 32'(7));
    repeat (3) @(negedge clk);
    #2 reset_b = 1'b0;
    #1;
    check("abort_cs", 32'(o_cs), 32'(1));
    check("abort_spi_clk", 32'(o_spi_clk), 32'(0));
    check("abort_valid", 32'(o_sample_valid), 32'(0));
    check("abort_busy", 32'(o_busy), 32'(0));
    sb_q.delete();
    vc0 = valid_cnt;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_no_valid", 32'(valid_cnt - vc0), 32'(0));

    run_frame('{10'h155, 10'h155, 201, NFrame, 200});

    check("no_x_on_sample", 32'(x_seen), 32'(0));
    check("no_sclk_with_cs_high", 32'(bad_clk), 32'(0));
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ltc1197_spi_master.md
Name: ltc1197_spi_master

Overview:
- SPI read master for the LTC1197 10-bit ADC (or its simulation emulator) in the acoustics acquisition path.
- Generates cs and spi_clk from the system clock, then deserialises the MSB-first sample on miso.
- Presents one 10-bit sample with a single-cycle valid strobe to the downstream sample buffer/filter chain.
- One conversion per start request; never overlaps frames.

Parameters:
CLK_HALF, 7, system clocks per spi_clk half-period (7 at 100 MHz gives 140 ns period)
N_FRAME, 14, spi_clk periods per frame (cs low)
N_SKIP, 3, leading spi_clk periods with no valid data (sample + null/Hi-Z)
N_DATA, 10, data bits per sample, MSB first
T_CSS, 4, system clocks from cs falling to first spi_clk rising edge
T_CSH, 14, minimum system clocks cs stays high between frames

Ports:
clk  in  1  system clock
reset_b  in  1  asynchronous, active-low reset
start  in  1  request one conversion; sampled only in IDLE
miso  in  1  ADC serial data (may be Z/X outside data bits)
cs  out  1  ADC chip select, active low
spi_clk  out  1  serial clock, idles low
sample  out  N_DATA  last completed conversion result
sample_valid  out  1  one-cycle strobe; sample is new on this cycle
busy  out  1  high from accepting start until end of RECOVER

Behaviour:
- Reset: cs=1, spi_clk=0, sample=0, sample_valid=0, busy=0, state=IDLE, all counters 0. Reset is asynchronous: assertion mid-frame forces cs high and spi_clk low immediately. The aborted frame produces no valid strobe.
- States: IDLE -> SETUP -> SCLK_HI -> SCLK_LO -> (repeat N_FRAME periods) -> RECOVER -> IDLE.
- IDLE: cs=1, spi_clk=0, busy=0. start=1 at a clk edge -> SETUP. On the next cycle cs=0 and busy=1.
- SETUP: hold cs=0 and spi_clk=0 for T_CSS cycles, then -> SCLK_HI with period index p=0.
- SCLK_HI: spi_clk=1 for CLK_HALF cycles, then -> SCLK_LO.
- SCLK_LO: spi_clk=0 for CLK_HALF cycles.
  - On the last cycle of SCLK_LO for period p, capture miso if N_SKIP <= p < N_SKIP+N_DATA: shift left into the assembly register, LSB-in.
  - This samples the bit the ADC launched after rising edge p, at least 68 ns earlier.
  - Then p+1: if p+1 < N_FRAME -> SCLK_HI; else -> RECOVER.
- Entering RECOVER: cs=1 and spi_clk=0. sample <= assembly register. sample_valid=1 for exactly that one cycle.
- RECOVER: cs held high T_CSH cycles, busy=1. Then -> IDLE.
- Latency, start edge to sample_valid: 1 + T_CSS + 2*CLK_HALF*N_FRAME cycles (201 at defaults).
- spi_clk rising edges per frame: exactly N_FRAME. spi_clk is never high while cs=1.
- start while busy=1 is ignored; no queuing. A start held continuously restarts in the first IDLE cycle.
- miso during skip periods or while cs=1 is never captured. X/Z on miso outside data bits must not reach sample.
- sample holds its value until the next completed frame.
- Counters: half-period counter ceil(log2(CLK_HALF)) bits; period counter ceil(log2(N_FRAME+1)) bits. No wrap-around within a frame.

Decomposition:
- Shared package: LTC1197 frame constants (N_FRAME, N_SKIP, N_DATA), default CLK_HALF and timing constants, and the state encoding (IDLE, SETUP, SCLK_HI, SCLK_LO, RECOVER).
- One natural sub-module: spi_half_timer, a loadable down-counter giving a terminal-count pulse. It is reused for the SETUP, half-period and RECOVER durations.

Test Plan:
- Reset: hold reset_b=0 -> cs=1, spi_clk=0, sample=0, sample_valid=0, busy=0. Release with start=0 -> outputs unchanged for 100 cycles.
- Single conversion against the ADC emulator with data_in=10'h2A5:
  - sample_valid exactly 201 cycles after the start edge, with sample=10'h2A5.
  - 14 spi_clk rising edges while cs=0.
  - cs low for 200 cycles.
- Extremes: data_in=10'h3FF, then 10'h000, with miso Z during skip periods -> sample=3FF, then 000. No X on sample at any time.
- Start handling:
  - start pulse while busy -> ignored; exactly one valid per frame.
  - start held high -> back-to-back frames with cs high >= 14 cycles between them.
- Reset during period 6 -> cs=1 and spi_clk=0 in the same cycle, no sample_valid, sample keeps its prior value. The next start produces a correct value (10'h155).
